// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl: pops an upstream fifo into a 2-entry output buffer with flush and pop counting
module fifo_pop_ctrl #(
    parameter int width = 16,
    parameter int cnt_w = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] fifo_dout,
    input  logic             fifo_pndng,
    output logic             fifo_pop,
    output logic [width-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    input  logic             flush,
    output logic             busy,
    output logic [cnt_w-1:0] pop_count
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_n;
    logic [1:0] cnt, cnt_n, wr_pos;
    logic [width-1:0] b1, b0_n, b1_n;
    logic xfer, ld;
    // Next-state, buffer movement and pop strobe; m_data is slot 0, b1 is slot 1
    always_comb begin
        m_valid  = cnt != 2'd0;
        busy     = state == FLUSH;
        xfer     = m_valid && m_ready;
        fifo_pop = rst && fifo_pndng && (state == FLUSH || cnt < 2'd2 || xfer);
        ld       = state != FLUSH && !flush;
        wr_pos   = cnt - {1'b0, xfer};
        cnt_n    = ld ? wr_pos + {1'b0, fifo_pop} : 2'd0;
        b0_n     = (ld && fifo_pop && wr_pos == 2'd0) ? fifo_dout :
                   (ld && xfer && cnt == 2'd2) ? b1 : m_data;
        b1_n     = (ld && fifo_pop && wr_pos == 2'd1) ? fifo_dout : b1;
        state_n  = (flush && state != FLUSH) ? FLUSH :
                   (state == IDLE) ? (fifo_pndng ? RUN : IDLE) :
                   (state == RUN) ? ((cnt_n == 2'd0 && !fifo_pndng) ? IDLE : RUN) :
                   ((!fifo_pndng && !flush) ? IDLE : FLUSH);
    end
    // State, buffer and pop counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            m_data    <= '0;
            b1        <= '0;
            pop_count <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            m_data    <= b0_n;
            b1        <= b1_n;
            pop_count <= pop_count + cnt_w'(fifo_pop);
        end
    end
endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// tb_fifo_pop_ctrl: directed vector table plus multi-cycle sequences for fifo_pop_ctrl
module tb_fifo_pop_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] fifo_dout = '0;
    logic        fifo_pndng = 1'b0;
    logic        fifo_pop;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic [15:0] pop_count;

    int vectors = 0;
    int fails = 0;
    int pops, bad_pops, hits;
    logic [15:0] q[$];
    logic [15:0] got[$];
    logic [15:0] pc0;

    typedef struct {
        logic        pndng;
        logic [15:0] dout;
        logic        rdy;
        logic        fl;
        logic        pop;
        logic        valid;
        logic [15:0] data;
        logic        bsy;
        logic [15:0] pc;
    } vec_t;
    vec_t tv[19];

    fifo_pop_ctrl #(.width(16), .cnt_w(16)) dut (
        .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_pndng(fifo_pndng),
        .fifo_pop(fifo_pop), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .flush(flush), .busy(busy), .pop_count(pop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_pndng = q.size() != 0;
        fifo_dout  = q.size() != 0 ? q[0] : 16'h0000;
    endtask

    task automatic cyc();
        logic sp;
        #4;
        sp = fifo_pop;
        if (fifo_pop && !fifo_pndng) bad_pops++;
        if (m_valid && m_ready) got.push_back(m_data);
        if (sp) pops++;
        @(posedge clk);
        #1;
        if (sp && q.size() != 0) void'(q.pop_front());
        drive_fifo();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        q.delete();
        got.delete();
        drive_fifo();
        m_ready = 1'b0;
        flush = 1'b0;
        pops = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bad_pops = 0;
        #1;
        chk("reset_valid", 32'(m_valid), 32'd0);
        chk("reset_pc", 32'(pop_count), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_data", 32'(m_data), 32'd0);
        // pndng dout rdy fl | pop valid data busy pc
        tv[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'd0};
        tv[1]  = '{1'b1, 16'hA5A5, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
        tv[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA5A5, 1'b0, 16'd1};
        tv[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA5A5, 1'b0, 16'd1};
        tv[4]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA5A5, 1'b0, 16'd1};
        tv[5]  = '{1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 16'd2};
        tv[6]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 16'd3};
        tv[7]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 16'd3};
        tv[8]  = '{1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 16'd3};
        tv[9]  = '{1'b1, 16'h0004, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 16'd4};
        tv[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 16'd5};
        tv[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0004, 1'b0, 16'd5};
        tv[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b0, 16'd5};
        tv[13] = '{1'b1, 16'h0007, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0004, 1'b0, 16'd5};
        tv[14] = '{1'b1, 16'h0008, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0007, 1'b0, 16'd6};
        tv[15] = '{1'b1, 16'h0009, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0007, 1'b1, 16'd7};
        tv[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0007, 1'b1, 16'd8};
        tv[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0007, 1'b1, 16'd8};
        tv[18] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0007, 1'b0, 16'd8};
        do_reset();
        for (int i = 0; i < 19; i++) begin
            fifo_pndng = tv[i].pndng;
            fifo_dout  = tv[i].dout;
            m_ready    = tv[i].rdy;
            flush      = tv[i].fl;
            #4;
            chk($sformatf("v%0d_pop", i), 32'(fifo_pop), 32'(tv[i].pop));
            chk($sformatf("v%0d_valid", i), 32'(m_valid), 32'(tv[i].valid));
            chk($sformatf("v%0d_data", i), 32'(m_data), 32'(tv[i].data));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].bsy));
            chk($sformatf("v%0d_pc", i), 32'(pop_count), 32'(tv[i].pc));
            @(posedge clk);
            #1;
        end
        flush = 1'b0;

        // backpressure then drain in order
        do_reset();
        for (int i = 1; i <= 5; i++) q.push_back(16'(i));
        drive_fifo();
        repeat (6) cyc();
        #4;
        chk("bp_pops", 32'(pops), 32'd2);
        chk("bp_pop_low", 32'(fifo_pop), 32'd0);
        chk("bp_data", 32'(m_data), 32'h0001);
        chk("bp_valid", 32'(m_valid), 32'd1);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        for (int i = 0; i < 30 && got.size() < 5; i++) cyc();
        repeat (3) cyc();
        chk("bp_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            chk($sformatf("bp_word%0d", i), 32'(got[i]), 32'(i + 1));

        // streaming at one word per cycle
        do_reset();
        for (int i = 0; i < 8; i++) q.push_back(16'h0100 + 16'(i));
        drive_fifo();
        m_ready = 1'b1;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            #4;
            if (fifo_pop) hits++;
            #0;
            cyc();
        end
        cyc();
        chk("st_pop_every_cycle", 32'(hits), 32'd8);
        chk("st_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk($sformatf("st_word%0d", i), 32'(got[i]), 32'h0100 + 32'(i));

        // flush with 6 pending upstream and 2 buffered
        do_reset();
        for (int i = 0; i < 8; i++) q.push_back(16'h0200 + 16'(i));
        drive_fifo();
        repeat (4) cyc();
        chk("fl_buffered", 32'(q.size()), 32'd6);
        pc0 = pop_count;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        m_ready = 1'b1;
        #1;
        chk("fl_valid_drop", 32'(m_valid), 32'd0);
        chk("fl_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 20 && busy; i++) cyc();
        chk("fl_idle", 32'(busy), 32'd0);
        chk("fl_pops", 32'(pop_count - pc0), 32'd6);
        chk("fl_no_output", 32'(got.size()), 32'd0);
        chk("fl_valid_end", 32'(m_valid), 32'd0);

        // pop counter wrap and asynchronous reset
        do_reset();
        fifo_pndng = 1'b1;
        fifo_dout = 16'h1234;
        m_ready = 1'b1;
        for (int i = 0; i < 70000 && pop_count !== 16'hFFFF; i++) begin
            @(posedge clk);
            #1;
        end
        chk("wrap_max", 32'(pop_count), 32'h0000FFFF);
        chk("wrap_pop", 32'(fifo_pop), 32'd1);
        @(posedge clk);
        #1;
        chk("wrap_zero", 32'(pop_count), 32'd0);
        #3;
        rst = 1'b0;
        #1;
        chk("ar_valid", 32'(m_valid), 32'd0);
        chk("ar_data", 32'(m_data), 32'd0);
        chk("ar_pop", 32'(fifo_pop), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_pc", 32'(pop_count), 32'd0);
        #1;
        rst = 1'b1;
        fifo_dout = 16'hBEEF;
        @(posedge clk);
        #1;
        chk("ar_restart_pc", 32'(pop_count), 32'd1);
        chk("ar_restart_valid", 32'(m_valid), 32'd1);
        chk("ar_restart_data", 32'(m_data), 32'h0000BEEF);
        chk("pop_without_pndng", 32'(bad_pops), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
